// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the processor pipeline stages.
//   WORD / REG_ADDR : default data word width and register-address width
//   mem_state_t     : states of the memory-access stage
//   wb_t            : write-back bundle (data, destination register, enable)
package proc_pkg;

    localparam int WORD     = 16;
    localparam int REG_ADDR = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic [WORD-1:0]     data;
        logic [REG_ADDR-1:0] rd;
        logic                en;
    } wb_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: saturating cycle counter that bounds how long the
// memory stage waits for read data.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : synchronous clear (wins over enable)
//   enable    : count one cycle
//   expired   : high during the enabled cycle whose increment brings the
//               count to TIMEOUT, so the caller leaves after exactly
//               TIMEOUT counted cycles
module mem_timeout_counter
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count stops at TIMEOUT instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: pipeline stage performing the data-memory access for the
// result of the execute stage, then registering the write-back bundle.
//   clk, rst                 : clock, asynchronous active-low reset
//   in_valid, aluout, bout,
//   rdout, memread, memwrite,
//   regwrite                 : instruction from the execute stage
//   stall                    : upstream must hold its outputs this cycle
//   mem_req, mem_we,
//   mem_addr, mem_wdata      : request side of the memory handshake
//   mem_ready, mem_rvalid,
//   mem_rdata                : memory acceptance and read-data return
//   wb_data, wb_rd, wb_en    : registered write-back to the register file
//   err                      : one-cycle pulse on timeout or illegal op
module memory_cycle
    import proc_pkg::*;
#(
    parameter int WIDTH   = WORD,
    parameter int RADDR   = REG_ADDR,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] bout,
    input  logic [RADDR-1:0] rdout,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             regwrite,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] wb_data,
    output logic [RADDR-1:0] wb_rd,
    output logic             wb_en,
    output logic             err
);

    mem_state_t state, next_state;

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [RADDR-1:0] rd_q;
    logic             regwrite_q;
    logic             load_q;
    logic             aborted_q;
    logic             expired;
    logic             is_mem_op;
    logic             is_illegal;
    logic             accepted;
    logic             waiting;

    assign is_mem_op  = memread ^ memwrite;
    assign is_illegal = memread & memwrite;
    assign accepted   = (state == REQ) && mem_ready;
    assign waiting    = (state == WAIT);

    // Address and data come straight from the latches, so they stay stable
    // for as long as the request is waiting for acceptance.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accepted),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests are decoded from the registered state, so an asynchronous
    // reset drops mem_req immediately. The IDLE stall is gated by reset so
    // stall reads 0 while reset is held.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && is_mem_op && rst) begin
                    stall      = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = ~load_q;
                if (mem_ready) begin
                    next_state = load_q ? WAIT : RESP;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid || expired) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latches for the in-flight instruction and the write-back registers.
    // wb_en and err default low so they only pulse for one cycle; wb_data
    // and wb_rd hold between loading edges. Read data arriving together
    // with the last allowed WAIT cycle still counts as a successful load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            load_q     <= 1'b0;
            aborted_q  <= 1'b0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_en      <= 1'b0;
            err        <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_illegal) begin
                            err <= 1'b1;
                        end else if (is_mem_op) begin
                            addr_q     <= aluout;
                            wdata_q    <= bout;
                            rd_q       <= rdout;
                            regwrite_q <= regwrite;
                            load_q     <= memread;
                            aborted_q  <= 1'b0;
                        end else begin
                            wb_data <= aluout;
                            wb_rd   <= rdout;
                            wb_en   <= regwrite;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                    end else if (expired) begin
                        aborted_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (aborted_q) begin
                        err <= 1'b1;
                    end else if (load_q) begin
                        wb_data <= rdata_q;
                        wb_rd   <= rd_q;
                        wb_en   <= regwrite_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: self-checking bench for memory_cycle. A transaction-level
// model (a word-addressed memory image and the expected write-back bundle)
// supplies every expected value; the bench itself plays the memory side.
module tb_memory_cycle;
    import proc_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] aluout;
    logic [15:0] bout;
    logic [3:0]  rdout;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_en;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_model [logic [15:0]];
    wb_t         exp_wb;

    memory_cycle #(
        .WIDTH   (16),
        .RADDR   (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .aluout     (aluout),
        .bout       (bout),
        .rdout      (rdout),
        .memread    (memread),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_en      (wb_en),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic [15:0] b,
                                 input logic [3:0] rd, input logic mr, input logic mw,
                                 input logic rw);
        in_valid = v;
        aluout   = alu;
        bout     = b;
        rdout    = rd;
        memread  = mr;
        memwrite = mw;
        regwrite = rw;
    endtask

    task automatic checkWbHeld(input string tag);
        checkOutput({tag, "_wb_data"}, 32'(wb_data), 32'(exp_wb.data));
        checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 32'(exp_wb.rd));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 16'($urandom), 16'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("idle_stall", 32'(stall), 0);
        checkOutput("idle_req", 32'(mem_req), 0);
        tick();
        checkOutput("idle_wb_en", 32'(wb_en), 0);
        checkOutput("idle_err", 32'(err), 0);
        checkWbHeld("idle");
    endtask

    task automatic doAlu(input logic [15:0] alu, input logic [3:0] rd, input logic rw);
        applyStimulus(1'b1, alu, 16'($urandom), rd, 1'b0, 1'b0, rw);
        #1;
        checkOutput("alu_stall", 32'(stall), 0);
        checkOutput("alu_req", 32'(mem_req), 0);
        tick();
        exp_wb.data = alu;
        exp_wb.rd   = rd;
        exp_wb.en   = rw;
        checkOutput("alu_wb_en", 32'(wb_en), 32'(exp_wb.en));
        checkOutput("alu_err", 32'(err), 0);
        checkWbHeld("alu");
    endtask

    task automatic doIllegal();
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("ill_stall", 32'(stall), 0);
        checkOutput("ill_req", 32'(mem_req), 0);
        tick();
        checkOutput("ill_err", 32'(err), 1);
        checkOutput("ill_wb_en", 32'(wb_en), 0);
        checkWbHeld("ill");
    endtask

    task automatic doStore(input logic [15:0] addr, input logic [15:0] data, input int ready_delay);
        applyStimulus(1'b1, addr, data, 4'($urandom), 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("st_idle_stall", 32'(stall), 1);
        checkOutput("st_idle_req", 32'(mem_req), 0);
        tick();
        for (int i = 0; i <= ready_delay; i++) begin
            mem_ready = (i == ready_delay);
            #1;
            checkOutput("st_req", 32'(mem_req), 1);
            checkOutput("st_we", 32'(mem_we), 1);
            checkOutput("st_addr", 32'(mem_addr), 32'(addr));
            checkOutput("st_wdata", 32'(mem_wdata), 32'(data));
            checkOutput("st_req_stall", 32'(stall), 1);
            tick();
        end
        mem_ready = 1'b0;
        mem_model[addr] = data;
        #1;
        checkOutput("st_resp_stall", 32'(stall), 0);
        checkOutput("st_resp_req", 32'(mem_req), 0);
        tick();
        checkOutput("st_wb_en", 32'(wb_en), 0);
        checkOutput("st_err", 32'(err), 0);
        checkWbHeld("st");
    endtask

    // Loads return the memory image's value; with timeout set the bench
    // never answers and expects an abort after exactly TIMEOUT WAIT cycles.
    task automatic doLoad(input logic [15:0] addr, input logic [3:0] rd, input logic rw,
                          input int ready_delay, input int rvalid_delay, input bit timeout);
        logic [15:0] data;
        if (mem_model.exists(addr)) data = mem_model[addr];
        else begin
            data = 16'($urandom);
            mem_model[addr] = data;
        end
        applyStimulus(1'b1, addr, 16'($urandom), rd, 1'b1, 1'b0, rw);
        #1;
        checkOutput("ld_idle_stall", 32'(stall), 1);
        checkOutput("ld_idle_req", 32'(mem_req), 0);
        tick();
        for (int i = 0; i <= ready_delay; i++) begin
            mem_ready  = (i == ready_delay);
            mem_rvalid = (i == ready_delay);
            mem_rdata  = ~data;
            #1;
            checkOutput("ld_req", 32'(mem_req), 1);
            checkOutput("ld_we", 32'(mem_we), 0);
            checkOutput("ld_addr", 32'(mem_addr), 32'(addr));
            checkOutput("ld_req_stall", 32'(stall), 1);
            tick();
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i < (timeout ? TIMEOUT : rvalid_delay); i++) begin
            #1;
            checkOutput("ld_wait_stall", 32'(stall), 1);
            checkOutput("ld_wait_req", 32'(mem_req), 0);
            tick();
        end
        if (!timeout) begin
            mem_rvalid = 1'b1;
            mem_rdata  = data;
            #1;
            checkOutput("ld_rv_stall", 32'(stall), 1);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        #1;
        checkOutput("ld_resp_stall", 32'(stall), 0);
        checkOutput("ld_resp_req", 32'(mem_req), 0);
        tick();
        if (timeout) begin
            checkOutput("ld_to_err", 32'(err), 1);
            checkOutput("ld_to_wb_en", 32'(wb_en), 0);
        end else begin
            exp_wb.data = data;
            exp_wb.rd   = rd;
            exp_wb.en   = rw;
            checkOutput("ld_err", 32'(err), 0);
            checkOutput("ld_wb_en", 32'(wb_en), 32'(exp_wb.en));
        end
        checkWbHeld("ld");
    endtask

    initial begin
        rst        = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        exp_wb     = '0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_req", 32'(mem_req), 0);
        checkOutput("rst_stall", 32'(stall), 0);
        checkOutput("rst_wb_en", 32'(wb_en), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkWbHeld("rst");
        rst = 1'b1;
        tick();

        $display("[TB] directed steps");
        doAlu(16'h0003, 4'd5, 1'b1);
        idleCycle();
        doStore(16'h0010, 16'hBEEF, 0);
        idleCycle();
        doLoad(16'h0010, 4'd3, 1'b1, 0, 0, 1'b0);
        mem_model[16'h0020] = 16'h1234;
        doLoad(16'h0020, 4'd3, 1'b1, 3, 1, 1'b0);
        idleCycle();
        doLoad(16'h0030, 4'd7, 1'b1, 1, 0, 1'b1);
        doAlu(16'h0055, 4'd9, 1'b1);
        doLoad(16'h0040, 4'd2, 1'b1, 0, TIMEOUT - 1, 1'b0);
        doIllegal();
        idleCycle();

        $display("[TB] reset during WAIT");
        applyStimulus(1'b1, 16'h0050, 16'h0, 4'd6, 1'b1, 1'b0, 1'b1);
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        exp_wb = '0;
        checkOutput("mid_rst_req", 32'(mem_req), 0);
        checkOutput("mid_rst_stall", 32'(stall), 0);
        checkOutput("mid_rst_wb_en", 32'(wb_en), 0);
        checkWbHeld("mid_rst");
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("post_rst_wb_en", 32'(wb_en), 0);
        doLoad(16'h0050, 4'd6, 1'b1, 1, 2, 1'b0);

        $display("[TB] random steps");
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0: doAlu(16'($urandom), 4'($urandom), 1'($urandom));
                1: doStore(16'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 3)));
                2: doLoad(16'($urandom_range(0, 7)), 4'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 1)), 1'b0);
                3: doIllegal();
                default: idleCycle();
            endcase
        end
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
